wired_div_ctrl: RTL and testbench

- Issue/writeback controller sitting directly upstream of the fixed-latency 32-cycle radix-2 divider in the integer execute path.
- Accepts div/mod requests (signed/unsigned, 32-bit) over a valid/ready handshake, sequences the divider's start/busy protocol, selects quotient or remainder, and presents a tagged result over a valid/ready handshake.
- Holds a one-entry operand cache so a mod following a div (or vice versa) on the same operands and signedness completes without re-running the divider.

---
 rtl/wired_div_ctrl.sv | 158 +++++++++++++++
 tb/tb_wired_div_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wired_div_ctrl.sv
// -----------------------------------------------------------------------------
// wired_div_ctrl
//
// Issue/writeback controller placed in front of the fixed-latency (32-cycle)
// radix-2 divider in the integer execute path. It accepts div/mod requests,
// runs the divider's start/busy protocol, selects quotient or remainder and
// returns a tagged result. A one-entry operand cache lets a div following a
// mod (or the reverse) on identical operands and signedness complete without
// rerunning the divider.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                synchronous pipeline flush (any state -> IDLE)
//   in_valid/in_ready    request handshake
//   in_op                bit1 = unsigned, bit0 = mod
//   in_a, in_b, in_tag   dividend, divisor, opaque request tag
//   out_valid/out_ready  result handshake
//   out_data, out_tag    selected quotient/remainder and its tag
//   div_start            one-cycle start pulse to the divider
//   div_sign, div_a/b    signedness and operands, valid with div_start
//   div_busy             divider busy, high for 32 cycles after start
//   div_quo, div_rem     divider results, final once div_busy falls
// -----------------------------------------------------------------------------
module wired_div_ctrl #(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             div_start,
  output logic             div_sign,
  output logic [31:0]      div_a,
  output logic [31:0]      div_b,
  input  logic             div_busy,
  input  logic [31:0]      div_quo,
  input  logic [31:0]      div_rem
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Latched request
  logic [1:0]        op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;

  // One-entry operand cache
  logic              c_vld;
  logic              c_uns;
  logic [DATA_W-1:0] c_a;
  logic [DATA_W-1:0] c_b;
  logic [DATA_W-1:0] c_quo;
  logic [DATA_W-1:0] c_rem;

  logic first_wait;
  logic accept;
  logic hit;
  logic capture;
  logic abort_run;

  assign hit       = c_vld && (in_a == c_a) && (in_b == c_b) && (in_op[1] == c_uns);
  assign accept    = (state == IDLE) && in_valid && !flush;
  assign capture   = (state == WAIT) && !div_busy && !flush;
  // Abandoning a divider run leaves the cache untrustworthy only if the run
  // had been started; a flush in IDLE/DONE keeps the cached entry.
  assign abort_run = flush && ((state == START) || (state == WAIT));

  assign div_sign = ~op_q[1];
  assign div_a    = a_q;
  assign div_b    = b_q;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    div_start = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = hit ? DONE : START;
      end
      START: begin
        div_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (!div_busy) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Control state and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      c_vld      <= 1'b0;
      first_wait <= 1'b0;
      out_data   <= '0;
      out_tag    <= '0;
    end else begin
      state      <= state_nxt;
      first_wait <= (state == START) && !flush;
      if (abort_run)    c_vld <= 1'b0;
      else if (capture) c_vld <= 1'b1;
      if (accept) begin
        out_tag <= in_tag;
        if (hit) out_data <= in_op[0] ? c_rem : c_quo;
      end else if (capture) begin
        out_data <= op_q[0] ? div_rem : div_quo;
      end
    end
  end

  // Operand and cache payload registers, qualified by the control above
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= in_op;
      a_q  <= in_a;
      b_q  <= in_b;
    end
    if (capture) begin
      c_a   <= a_q;
      c_b   <= b_q;
      c_uns <= op_q[1];
      c_quo <= div_quo;
      c_rem <= div_rem;
    end
  end

  // The divider must report busy on the cycle right after the start pulse.
  a_busy_after_start: assert property (@(posedge clk) disable iff (!rst_n)
    (first_wait && !flush) |-> div_busy);

endmodule

// File: tb/tb_wired_div_ctrl.sv
module tb_wired_div_ctrl;
  localparam int TAG_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_a, in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             div_start, div_sign;
  logic [31:0]      div_a, div_b;
  logic             div_busy;
  logic [31:0]      div_quo, div_rem;

  wired_div_ctrl #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag),
    .div_start(div_start), .div_sign(div_sign), .div_a(div_a), .div_b(div_b),
    .div_busy(div_busy), .div_quo(div_quo), .div_rem(div_rem)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int starts_seen = 0;
  int starts_exp  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Architectural result of a 32-bit divide: {quotient, remainder}
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic uns);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (uns) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {q, r};
  endfunction

  // Divider model: start restarts it, busy 32 cycles, junk while busy
  int          dcnt;
  logic [63:0] dres;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt <= 0;
      dres <= '0;
    end else if (div_start) begin
      dcnt <= 32;
      dres <= ref_div(div_a, div_b, !div_sign);
    end else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
    end
  end
  assign div_busy = (dcnt != 0);
  assign div_quo  = div_busy ? 32'hDEAD_BEEF : dres[63:32];
  assign div_rem  = div_busy ? 32'hBAAD_F00D : dres[31:0];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard
  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    int               due;
  } exp_t;
  exp_t sbq[$];

  logic [31:0] cur_a, cur_b;
  logic        cur_uns;

  // Behavioural cache model
  logic        mc_valid = 1'b0;
  logic [31:0] mc_a, mc_b;
  logic        mc_uns;

  // Monitor
  logic pv = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (div_start) begin
        starts_seen <= starts_seen + 1;
        chk("div_a", div_a, cur_a);
        chk("div_b", div_b, cur_b);
        chk("div_sign", div_sign, !cur_uns);
      end
      if (out_valid) begin
        chk("in_ready_in_done", in_ready, 1'b0);
        if (sbq.size() == 0) begin
          chk("unexpected_out_valid", out_valid, 1'b0);
        end else begin
          if (!pv) chk("latency", cyc, sbq[0].due);
          chk("out_data", out_data, sbq[0].data);
          chk("out_tag", out_tag, sbq[0].tag);
          if (out_ready) void'(sbq.pop_front());
        end
      end
    end
    pv <= out_valid && rst_n;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    chk("in_ready_idle", in_ready, 1'b1);
  endtask

  // Full request; flush_done flushes instead of completing the handshake
  task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [7:0] tag, input int stall, input bit flush_done);
    int          k;
    logic        hit;
    logic [63:0] res;
    exp_t        e;
    wait_idle();
    hit    = mc_valid && a == mc_a && b == mc_b && op[1] == mc_uns;
    res    = ref_div(a, b, op[1]);
    e.data = op[0] ? res[31:0] : res[63:32];
    e.tag  = tag;
    e.due  = cyc + (hit ? 1 : 35);
    sbq.push_back(e);
    if (!hit) begin
      starts_exp++;
      mc_valid = 1'b1;
      mc_a = a;
      mc_b = b;
      mc_uns = op[1];
    end
    cur_a = a; cur_b = b; cur_uns = op[1];
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    tick();
    in_valid = 1'b0; in_op = 2'($urandom); in_a = $urandom; in_b = $urandom;
    in_tag = 8'($urandom);
    k = 0;
    while (!out_valid && k < 60) begin
      tick();
      k++;
    end
    chk("out_valid_timeout", out_valid, 1'b1);
    if (!out_valid) begin
      sbq.delete();
      return;
    end
    repeat (stall) tick();
    if (flush_done) begin
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_done_valid_drop", out_valid, 1'b0);
      sbq.delete();
      return;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("valid_after_handshake", out_valid, 1'b0);
    chk("in_ready_after_handshake", in_ready, 1'b1);
  endtask

  // Start a miss and abandon it 5 cycles into WAIT: mode 0 flush, mode 1 reset
  task automatic abort_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [7:0] tag, input int mode);
    logic hit;
    wait_idle();
    hit = mc_valid && a == mc_a && b == mc_b && op[1] == mc_uns;
    if (!hit) starts_exp++;
    cur_a = a; cur_b = b; cur_uns = op[1];
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    if (mode == 0) begin
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_wait_valid", out_valid, 1'b0);
      chk("flush_wait_ready", in_ready, 1'b1);
    end else begin
      rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", in_ready, 1'b1);
      chk("midrst_div_start", div_start, 1'b0);
      chk("midrst_out_valid", out_valid, 1'b0);
      tick();
      rst_n = 1'b1;
    end
    mc_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = 2'b00; in_a = '0; in_b = '0; in_tag = '0;
    cur_a = '0; cur_b = '0; cur_uns = 1'b0;
    #3;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_div_start", div_start, 1'b0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_tag", out_tag, 8'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    do_req(2'b10, 32'd100, 32'd7, 8'h03, 0, 0);
    do_req(2'b01, 32'hFFFF_FFF9, 32'd2, 8'h11, 0, 0);
    do_req(2'b00, 32'hFFFF_FFF9, 32'd2, 8'h12, 0, 0);
    do_req(2'b11, 32'hFFFF_FFF9, 32'd2, 8'h13, 0, 0);
    do_req(2'b10, 32'h1234_5678, 32'd0, 8'h14, 0, 0);
    do_req(2'b11, 32'h1234_5678, 32'd0, 8'h15, 0, 0);
    do_req(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 8'h16, 0, 0);
    do_req(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 8'h17, 0, 0);
    do_req(2'b10, 32'd1000, 32'd3, 8'h55, 10, 0);

    do_req(2'b10, 32'd500, 32'd9, 8'h20, 0, 0);
    abort_req(2'b10, 32'd777, 32'd4, 8'h21, 0);
    do_req(2'b10, 32'd500, 32'd9, 8'h22, 0, 0);
    do_req(2'b10, 32'd60, 32'd5, 8'h23, 0, 0);
    do_req(2'b10, 32'd777, 32'd4, 8'h24, 0, 0);

    // Flush coinciding with a request in IDLE drops it
    in_valid = 1'b1; in_op = 2'b00; in_a = 32'd9; in_b = 32'd9; in_tag = 8'h99;
    flush = 1'b1;
    cur_a = 32'd9; cur_b = 32'd9; cur_uns = 1'b0;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_drop", in_ready, 1'b1);
    repeat (3) tick();

    do_req(2'b11, 32'd777, 32'd4, 8'h25, 0, 0);
    do_req(2'b10, 32'd777, 32'd4, 8'h26, 2, 1);
    do_req(2'b11, 32'd777, 32'd4, 8'h27, 0, 0);
    abort_req(2'b10, 32'd31, 32'd3, 8'h28, 1);
    do_req(2'b10, 32'd777, 32'd4, 8'h29, 0, 0);

    ra = 32'd1; rb = 32'd1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        ra = $urandom;
        case ($urandom_range(0, 5))
          0: rb = 32'd0;
          1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
          2: rb = 32'($urandom_range(1, 20));
          3: rb = -32'($urandom_range(1, 20));
          default: rb = $urandom;
        endcase
      end
      rop = 2'($urandom);
      do_req(rop, ra, rb, 8'(i + 8'h40), $urandom_range(0, 3), 0);
    end

    repeat (5) tick();
    chk("div_start_count", starts_seen, starts_exp);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
